// File: rtl/rv0_pkg.sv
// Shared types for the rv0 integer register file and its write-back port.
package rv0_pkg;
    localparam int REG_ADDR_W = 5;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rv_rwb_if.sv
// Register write-back bus.
// Handshake: no ready; a write is consumed by the sink on every posedge where we is high.
interface rv_rwb_if
    import rv0_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            we;
    reg_addr_t       waddr;
    logic [XLEN-1:0] wdata;

    modport source (output we, output waddr, output wdata);
    modport sink   (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/rv0_rfi_sb.sv
// Pending-write scoreboard: per-register in-flight counters, busy/issue_rdy and the
// sticky error raised by a write-back that nothing was waiting for.
module rv0_rfi_sb
    import rv0_pkg::*;
#(
    parameter int REG_CNT = 32,
    parameter int PEND_W  = 2,
    parameter int BYPASS  = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      wb_we_i,
    input  reg_addr_t wb_addr_i,
    input  logic      issue_we_i,
    input  reg_addr_t issue_rd_i,
    input  logic      flush_i,
    input  reg_addr_t rs1_addr_i,
    input  reg_addr_t rs2_addr_i,
    output logic      rs1_busy_o,
    output logic      rs2_busy_o,
    output logic      issue_rdy_o,
    output logic      err_o
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] cnt_q [REG_CNT];
    logic [PEND_W-1:0] cnt_d [REG_CNT];
    logic              err_q, err_d;
    logic              inc, dec, wb_valid, wb_orphan;

    // issue_rdy looks only at registered counters so write-back never reaches it combinationally.
    assign issue_rdy_o = (issue_rd_i == '0) || (cnt_q[issue_rd_i] != CNT_MAX);
    assign inc         = issue_we_i && issue_rdy_o && (issue_rd_i != '0);
    assign wb_valid    = wb_we_i && (wb_addr_i != '0);
    assign dec         = wb_valid && (cnt_q[wb_addr_i] != '0);
    assign wb_orphan   = wb_valid && (cnt_q[wb_addr_i] == '0);
    assign err_d       = err_q | wb_orphan;
    assign err_o       = err_q;

    function automatic logic busy_of(reg_addr_t a);
        logic drop;
        drop = (BYPASS != 0) && dec && (wb_addr_i == a) && (cnt_q[a] == CNT_ONE)
               && !(inc && (issue_rd_i == a));
        return (a != '0) && (cnt_q[a] != '0) && !drop;
    endfunction

    assign rs1_busy_o = busy_of(rs1_addr_i);
    assign rs2_busy_o = busy_of(rs2_addr_i);

    always_comb begin
        for (int i = 0; i < REG_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush_i) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i]
                         + PEND_W'(inc && (issue_rd_i == reg_addr_t'(i)))
                         - PEND_W'(dec && (wb_addr_i == reg_addr_t'(i)));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_CNT; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < REG_CNT; i++) cnt_q[i] <= cnt_d[i];
            err_q <= err_d;
        end
    end
endmodule

// File: rtl/rv0_rfi.sv
// Integer register file: write-back sink, two combinational read ports with optional
// same-cycle forwarding, and a pending-write scoreboard for decode stalls.
module rv0_rfi
    import rv0_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_CNT = 32,
    parameter int PEND_W  = 2,
    parameter int BYPASS  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    rv_rwb_if.sink          rfi_if,
    input  reg_addr_t       rs1_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic            rs1_busy_o,
    input  reg_addr_t       rs2_addr_i,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs2_busy_o,
    input  logic            issue_we_i,
    input  reg_addr_t       issue_rd_i,
    output logic            issue_rdy_o,
    input  logic            flush_i,
    output logic            err_o
);
    logic [XLEN-1:0] regs_q [REG_CNT];
    logic            wr_en;

    assign wr_en = rfi_if.we && (rfi_if.waddr != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[rfi_if.waddr] <= rfi_if.wdata;
        end
    end

    function automatic logic [XLEN-1:0] read_port(reg_addr_t a);
        if (a == '0)                                    return '0;
        if ((BYPASS != 0) && wr_en && rfi_if.waddr == a) return rfi_if.wdata;
        return regs_q[a];
    endfunction

    assign rs1_data_o = read_port(rs1_addr_i);
    assign rs2_data_o = read_port(rs2_addr_i);

    rv0_rfi_sb #(
        .REG_CNT (REG_CNT),
        .PEND_W  (PEND_W),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb_we_i     (rfi_if.we),
        .wb_addr_i   (rfi_if.waddr),
        .issue_we_i  (issue_we_i),
        .issue_rd_i  (issue_rd_i),
        .flush_i     (flush_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_busy_o  (rs1_busy_o),
        .rs2_busy_o  (rs2_busy_o),
        .issue_rdy_o (issue_rdy_o),
        .err_o       (err_o)
    );
endmodule

// File: tb/tb_rv0_rfi.sv
// Directed bench for rv0_rfi: behavioural model checked every cycle plus literal spot checks.
module tb_rv0_rfi;
    import rv0_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    reg_addr_t   rs1_addr = '0, rs2_addr = '0, issue_rd = '0;
    logic        issue_we = 1'b0, flush = 1'b0;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy, issue_rdy, err;

    int tests = 0;
    int fails = 0;

    rv_rwb_if #(.XLEN(32)) wb_if ();

    rv0_rfi dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rfi_if      (wb_if),
        .rs1_addr_i  (rs1_addr),
        .rs1_data_o  (rs1_data),
        .rs1_busy_o  (rs1_busy),
        .rs2_addr_i  (rs2_addr),
        .rs2_data_o  (rs2_data),
        .rs2_busy_o  (rs2_busy),
        .issue_we_i  (issue_we),
        .issue_rd_i  (issue_rd),
        .issue_rdy_o (issue_rdy),
        .flush_i     (flush),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural register values and in-flight counts.
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_err;

    function automatic bit m_rdy();
        return (issue_rd == 0) || (m_cnt[issue_rd] < 3);
    endfunction

    function automatic bit m_inc_to(int a);
        return issue_we && m_rdy() && issue_rd != 0 && issue_rd == a;
    endfunction

    function automatic logic [31:0] m_data(int a);
        if (a == 0) return 32'h0;
        if (wb_if.we && wb_if.waddr == a) return wb_if.wdata;
        return m_reg[a];
    endfunction

    function automatic bit m_busy(int a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (wb_if.we && wb_if.waddr == a && m_cnt[a] == 1 && !m_inc_to(a)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = '0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            int  wa;
            bit  do_inc, do_dec;
            wa     = int'(wb_if.waddr);
            do_inc = issue_we && m_rdy() && issue_rd != 0;
            do_dec = wb_if.we && wa != 0 && m_cnt[wa] > 0;
            if (wb_if.we && wa != 0 && m_cnt[wa] == 0) m_err = 1'b1;
            if (wb_if.we && wa != 0) m_reg[wa] = wb_if.wdata;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else begin
                if (do_inc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
                if (do_dec) m_cnt[wa] = m_cnt[wa] - 1;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=0x%08h expected=0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_rs1_data", rs1_data, m_data(int'(rs1_addr)));
            chk("mdl_rs2_data", rs2_data, m_data(int'(rs2_addr)));
            chk("mdl_rs1_busy", 32'(rs1_busy), 32'(m_busy(int'(rs1_addr))));
            chk("mdl_rs2_busy", 32'(rs2_busy), 32'(m_busy(int'(rs2_addr))));
            chk("mdl_issue_rdy", 32'(issue_rdy), 32'(m_rdy()));
            chk("mdl_err", 32'(err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_we    = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
        wb_if.we    = 1'b0;
        wb_if.waddr = '0;
        wb_if.wdata = '0;
    endtask

    task automatic wb(reg_addr_t a, logic [31:0] d);
        wb_if.we    = 1'b1;
        wb_if.waddr = a;
        wb_if.wdata = d;
    endtask

    task automatic issue(reg_addr_t rd);
        issue_we = 1'b1;
        issue_rd = rd;
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state across all addresses
        for (int a = 0; a < 32; a++) begin
            cyc();
            rs1_addr = reg_addr_t'(a);
            rs2_addr = reg_addr_t'(31 - a);
            #2;
            chk("rst_rs1_data", rs1_data, 32'h0);
            chk("rst_rs2_busy", 32'(rs2_busy), 32'h0);
        end
        chk("rst_issue_rdy", 32'(issue_rdy), 32'h1);
        chk("rst_err", 32'(err), 32'h0);

        // 2: issue x5 then write back with forwarding
        cyc(); rs1_addr = 5'd5; rs2_addr = 5'd0; issue(5'd5);
        #2 chk("t2_busy_pre", 32'(rs1_busy), 32'h0);
        cyc(); idle();
        #2 chk("t2_busy_after_issue", 32'(rs1_busy), 32'h1);
        cyc(); wb(5'd5, 32'hDEADBEEF);
        #2 chk("t2_bypass_data", rs1_data, 32'hDEADBEEF);
        chk("t2_bypass_busy", 32'(rs1_busy), 32'h0);
        cyc(); idle();
        #2 chk("t2_data_after", rs1_data, 32'hDEADBEEF);
        chk("t2_busy_after", 32'(rs1_busy), 32'h0);

        // 3: saturate x7
        rs1_addr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            cyc(); issue(5'd7);
            #2 chk("t3_rdy_filling", 32'(issue_rdy), 32'h1);
        end
        cyc(); issue(5'd7);
        #2 chk("t3_rdy_full", 32'(issue_rdy), 32'h0);
        chk("t3_busy_full", 32'(rs1_busy), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            cyc(); idle(); wb(5'd7, 32'(k));
            #2 chk("t3_wb_busy", 32'(rs1_busy), (k == 3) ? 32'h0 : 32'h1);
        end
        cyc(); idle();
        #2 chk("t3_final_busy", 32'(rs1_busy), 32'h0);
        chk("t3_final_data", rs1_data, 32'h3);
        chk("t3_err", 32'(err), 32'h0);

        // 4: simultaneous issue and write-back on x3
        cyc(); rs1_addr = 5'd3; issue(5'd3);
        cyc(); issue(5'd3); wb(5'd3, 32'h0000_00A5);
        #2 chk("t4_busy_same", 32'(rs1_busy), 32'h1);
        chk("t4_data_same", rs1_data, 32'h0000_00A5);
        cyc(); idle();
        #2 chk("t4_busy_after", 32'(rs1_busy), 32'h1);
        chk("t4_data_after", rs1_data, 32'h0000_00A5);
        cyc(); wb(5'd3, 32'h0000_00B6);
        #2 chk("t4_drain_busy", 32'(rs1_busy), 32'h0);
        cyc(); idle();

        // 5: x0 write and issue are no-ops
        cyc(); rs1_addr = 5'd0; wb(5'd0, 32'h0000_1234); issue(5'd0);
        #2 chk("t5_x0_data", rs1_data, 32'h0);
        chk("t5_x0_busy", 32'(rs1_busy), 32'h0);
        chk("t5_x0_rdy", 32'(issue_rdy), 32'h1);
        cyc(); idle();
        #2 chk("t5_x0_data_after", rs1_data, 32'h0);
        chk("t5_err", 32'(err), 32'h0);

        // 6: flush with same-cycle write-back, then an orphan write-back
        cyc(); rs1_addr = 5'd9; issue(5'd9);
        cyc(); issue(5'd9);
        cyc(); idle();
        #2 chk("t6_busy_cnt2", 32'(rs1_busy), 32'h1);
        cyc(); flush = 1'b1; wb(5'd9, 32'h0000_0055);
        #2 chk("t6_err_flush", 32'(err), 32'h0);
        cyc(); idle();
        #2 chk("t6_busy_flushed", 32'(rs1_busy), 32'h0);
        chk("t6_data_55", rs1_data, 32'h0000_0055);
        chk("t6_err_still0", 32'(err), 32'h0);
        cyc(); wb(5'd9, 32'h0000_0066);
        #2 chk("t6_err_pre", 32'(err), 32'h0);
        cyc(); idle();
        #2 chk("t6_err_set", 32'(err), 32'h1);
        chk("t6_data_66", rs1_data, 32'h0000_0066);
        cyc();
        #2 chk("t6_err_sticky", 32'(err), 32'h1);

        // Asynchronous reset mid-operation
        cyc(); rs1_addr = 5'd4; issue(5'd4);
        cyc(); idle();
        #2 chk("rst2_busy_pre", 32'(rs1_busy), 32'h1);
        rst = 1'b1;
        #1 chk("rst2_busy", 32'(rs1_busy), 32'h0);
        rs1_addr = 5'd9;
        #1 chk("rst2_data", rs1_data, 32'h0);
        chk("rst2_err", 32'(err), 32'h0);
        cyc(); rst = 1'b0;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
